// File: rtl/dft_pkg.sv
// Shared types and constants for the scan-chain unloader.
package dft_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LAST  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dft_word_packer.sv
// Per-chain 32-bit word assembler: indexed bit write, cleared at each word start.
module dft_word_packer
   import dft_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cap,
   input  logic              commit,
   input  logic              sin,
   input  logic [4:0]        bit_idx,
   output logic [WORD_W-1:0] word
);

   logic [WORD_W-1:0] acc_q;
   logic [WORD_W-1:0] acc_d;

   // Bit 0 starts a fresh word, so untouched high bits of a short word stay zero.
   always_comb begin
      acc_d          = (bit_idx == 5'd0) ? '0 : acc_q;
      acc_d[bit_idx] = sin;
   end

   // Accumulate captured bits; publish the completed word on commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         word  <= '0;
      end else begin
         if (cap)    acc_q <= acc_d;
         if (commit) word  <= acc_d;
      end
   end

endmodule

// File: rtl/dft_scan_unloader.sv
// Scan-chain unloader: shifts up to P_SC_NBR chains, packs bits into 32-bit
// words and emits one-cycle write strobes with per-chain word addresses.
module dft_scan_unloader
   import dft_pkg::*;
#(
   parameter int P_SC_NBR = 16,
   parameter int P_WORDS  = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [31:0]                scan_len,
   input  logic [P_SC_NBR-1:0]        chain_mask,
   input  logic [P_SC_NBR-1:0]        scan_out,
   output logic                       scan_en,
   output logic [32*P_SC_NBR-1:0]     dft_output_data,
   output logic [32*P_SC_NBR-1:0]     dft_output_data_wraddr,
   output logic [P_SC_NBR-1:0]        dft_wen,
   output logic                       busy,
   output logic                       done
);

   localparam int          WC_W    = clog2(P_WORDS) + 1;
   localparam logic [31:0] MAX_LEN = 32'(WORD_W * P_WORDS);

   state_t                state, state_n;
   logic [31:0]           len_q;
   logic [31:0]           len_in;
   logic [P_SC_NBR-1:0]   mask_q;
   logic [4:0]            bit_cnt;
   logic [WC_W-1:0]       word_cnt;
   logic [31:0]           total_cnt;
   logic [31:0]           wraddr_q;
   logic                  cap;
   logic                  last_bit;
   logic                  word_end;

   assign len_in = (scan_len > MAX_LEN) ? MAX_LEN : scan_len;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next state, capture/commit strobes and status outputs.
   always_comb begin
      state_n  = state;
      cap      = 1'b0;
      last_bit = 1'b0;
      word_end = 1'b0;
      scan_en  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_n = (len_in == 32'd0) ? DONE : SHIFT;
         end
         SHIFT: begin
            scan_en  = 1'b1;
            busy     = 1'b1;
            cap      = 1'b1;
            last_bit = (total_cnt + 32'd1 == len_q);
            word_end = (bit_cnt == 5'd31) || last_bit;
            if (last_bit) state_n = LAST;
         end
         LAST: begin
            busy    = 1'b1;
            state_n = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Length/mask latch, bit/word/total counters and write strobe/address.
   always_ff @(posedge clk) begin
      if (reset) begin
         len_q     <= '0;
         mask_q    <= '0;
         bit_cnt   <= '0;
         word_cnt  <= '0;
         total_cnt <= '0;
         wraddr_q  <= '0;
         dft_wen   <= '0;
      end else begin
         if (state == IDLE && start) begin
            len_q     <= len_in;
            mask_q    <= chain_mask;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            total_cnt <= '0;
         end
         if (cap) begin
            bit_cnt   <= bit_cnt + 5'd1;
            total_cnt <= total_cnt + 32'd1;
         end
         dft_wen <= word_end ? mask_q : '0;
         if (word_end) begin
            wraddr_q <= 32'(word_cnt);
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

   genvar i;
   generate
      for (i = 0; i < P_SC_NBR; i++) begin : g_chain
         dft_word_packer u_packer (
            .clk     (clk),
            .reset   (reset),
            .cap     (cap),
            .commit  (word_end),
            .sin     (scan_out[i]),
            .bit_idx (bit_cnt),
            .word    (dft_output_data[32*i +: 32])
         );
         assign dft_output_data_wraddr[32*i +: 32] = wraddr_q;
      end
   endgenerate

endmodule

// File: tb/tb_dft_scan_unloader.sv
// Directed bench for dft_scan_unloader with two chains and four words per chain.
module tb_dft_scan_unloader;
   import dft_pkg::*;

   localparam int NC = 2;
   localparam int NW = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [31:0]       scan_len;
   logic [NC-1:0]     chain_mask;
   logic [NC-1:0]     scan_out;
   logic              scan_en;
   logic [32*NC-1:0]  dft_output_data;
   logic [32*NC-1:0]  dft_output_data_wraddr;
   logic [NC-1:0]     dft_wen;
   logic              busy;
   logic              done;

   dft_scan_unloader #(.P_SC_NBR(NC), .P_WORDS(NW)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .start                  (start),
      .scan_len               (scan_len),
      .chain_mask             (chain_mask),
      .scan_out               (scan_out),
      .scan_en                (scan_en),
      .dft_output_data        (dft_output_data),
      .dft_output_data_wraddr (dft_output_data_wraddr),
      .dft_wen                (dft_wen),
      .busy                   (busy),
      .done                   (done)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [31:0] wr_d0[$];
   logic [31:0] wr_d1[$];
   logic [31:0] wr_a0[$];
   logic [31:0] wr_a1[$];
   logic [31:0] wr_w[$];
   int          wr_c[$];
   logic [NC-1:0] wen_or;
   int en_cnt, done_n, done_cyc, tmo;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [NC-1:0] pat(input int mode, input int c);
      if (mode == 0) return {1'b1, (c % 2 == 1)};
      return 2'b11;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start an unload at edge E0 and record everything until busy falls.
   task automatic run(input logic [31:0] len, input logic [NC-1:0] mask,
                      input int mode, input int restart_at);
      wr_d0.delete(); wr_d1.delete(); wr_a0.delete(); wr_a1.delete();
      wr_w.delete(); wr_c.delete();
      wen_or = '0; en_cnt = 0; done_n = 0; done_cyc = -1; tmo = 1;
      scan_len = len; chain_mask = mask; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 400; c++) begin
         scan_out = pat(mode, c);
         start    = (c == restart_at);
         if (scan_en) en_cnt++;
         if (dft_wen != '0) begin
            wr_d0.push_back(dft_output_data[31:0]);
            wr_d1.push_back(dft_output_data[63:32]);
            wr_a0.push_back(dft_output_data_wraddr[31:0]);
            wr_a1.push_back(dft_output_data_wraddr[63:32]);
            wr_w.push_back(32'(dft_wen));
            wr_c.push_back(c);
            wen_or = wen_or | dft_wen;
         end
         if (done) begin
            done_n++;
            done_cyc = c;
         end
         if (!busy) begin
            tmo = 0;
            break;
         end
         step();
      end
      start = 1'b0;
      chk("timeout", 32'(tmo), 32'd0);
   endtask

   task automatic check_full(input string t);
      chk({t, "_en"},     32'(en_cnt), 32'd64);
      chk({t, "_nwr"},    32'(wr_c.size()), 32'd2);
      chk({t, "_wen0"},   wr_w[0], 32'h3);
      chk({t, "_cyc0"},   32'(wr_c[0]), 32'd33);
      chk({t, "_d0w0"},   wr_d0[0], 32'h5555_5555);
      chk({t, "_d1w0"},   wr_d1[0], 32'hFFFF_FFFF);
      chk({t, "_a0w0"},   wr_a0[0], 32'd0);
      chk({t, "_cyc1"},   32'(wr_c[1]), 32'd65);
      chk({t, "_d0w1"},   wr_d0[1], 32'h5555_5555);
      chk({t, "_d1w1"},   wr_d1[1], 32'hFFFF_FFFF);
      chk({t, "_a0w1"},   wr_a0[1], 32'd1);
      chk({t, "_a1w1"},   wr_a1[1], 32'd1);
      chk({t, "_ndone"},  32'(done_n), 32'd1);
      chk({t, "_donecyc"}, 32'(done_cyc), 32'd66);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; scan_len = '0; chain_mask = '0; scan_out = '0;
      repeat (3) step();
      // Reset state
      chk("rst_en",   32'(scan_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wen",  32'(dft_wen), 32'd0);
      chk("rst_data", dft_output_data[31:0] | dft_output_data[63:32], 32'd0);
      chk("rst_addr", dft_output_data_wraddr[31:0], 32'd0);
      reset = 1'b0;
      step();

      // Full words, alternating chain0 / constant chain1
      run(32'd64, 2'b11, 0, 0);
      check_full("full");
      step();

      // Partial last word zero-padded
      run(32'd40, 2'b11, 1, 0);
      chk("part_en",    32'(en_cnt), 32'd40);
      chk("part_nwr",   32'(wr_c.size()), 32'd2);
      chk("part_d0w0",  wr_d0[0], 32'hFFFF_FFFF);
      chk("part_d0w1",  wr_d0[1], 32'h0000_00FF);
      chk("part_d1w1",  wr_d1[1], 32'h0000_00FF);
      chk("part_a0w1",  wr_a0[1], 32'd1);
      chk("part_cyc1",  32'(wr_c[1]), 32'd41);
      chk("part_done",  32'(done_cyc), 32'd42);
      step();

      // Zero length
      run(32'd0, 2'b11, 1, 0);
      chk("zero_en",   32'(en_cnt), 32'd0);
      chk("zero_nwr",  32'(wr_c.size()), 32'd0);
      chk("zero_ndone", 32'(done_n), 32'd1);
      chk("zero_done", 32'(done_cyc), 32'd1);
      step();

      // Clamp to 32*NW bits, only chain 0 enabled
      run(32'(32 * NW + 100), 2'b01, 1, 0);
      chk("clamp_en",    32'(en_cnt), 32'(32 * NW));
      chk("clamp_nwr",   32'(wr_c.size()), 32'(NW));
      chk("clamp_last",  wr_a0[NW-1], 32'(NW - 1));
      chk("clamp_wenor", 32'(wen_or), 32'h1);
      chk("clamp_done",  32'(done_cyc), 32'(32 * NW + 2));
      step();

      // Reset sampled at E20 of a 64-bit unload
      scan_len = 32'd64; chain_mask = 2'b11; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 20; c++) begin
         scan_out = pat(0, c);
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_en",    32'(scan_en), 32'd0);
      chk("mid_busy",  32'(busy), 32'd0);
      chk("mid_done",  32'(done), 32'd0);
      chk("mid_wen",   32'(dft_wen), 32'd0);
      chk("mid_data",  dft_output_data[31:0] | dft_output_data[63:32], 32'd0);
      chk("mid_addr",  dft_output_data_wraddr[31:0], 32'd0);
      chk("mid_state", 32'(dut.state), 32'(IDLE));
      step();
      run(32'd64, 2'b11, 0, 0);
      check_full("post");
      step();

      // Start while busy is ignored
      run(32'd64, 2'b11, 0, 10);
      check_full("rbusy");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
